// File: rtl/icache_ctrl_nway.sv
// N-way set-associative icache controller: round-robin victim selection and multi-beat line refill.
// Optional hit/miss performance counters are enabled with `define ICACHE_PERF_CNT_EN.
module icache_ctrl_nway #(
  parameter int NUM_WAYS   = 4,
  parameter int NUM_SETS   = 64,
  parameter int LINE_BEATS = 4,
  parameter int WAY_W      = $clog2(NUM_WAYS),
  parameter int IDX_W      = $clog2(NUM_SETS),
  parameter int BEAT_W     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if2icache_req_i,
  input  logic                if2icache_req_kill_i,
  input  logic                imem_sel_i,
  input  logic [IDX_W-1:0]    set_idx_i,
  input  logic [NUM_WAYS-1:0] hit_way_i,
  output logic                icache2if_ack_o,
  output logic                icache2mem_req_o,
  input  logic                mem2icache_ack_i,
  output logic [WAY_W-1:0]    fill_way_o,
  output logic [BEAT_W-1:0]   fill_beat_o,
  output logic                cache_wr_o,
  output logic                tag_wr_o,
  output logic                busy_o
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o
`endif
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state_q, state_d;
  logic              ack_q;
  logic [IDX_W-1:0]  set_q;
  logic [WAY_W-1:0]  way_q;
  logic [BEAT_W-1:0] beat_q;
  logic [WAY_W-1:0]  rr_q [NUM_SETS];

  logic lookup, hit, miss, abort, last_beat;
  logic start_fill, fill_done;

  assign lookup    = if2icache_req_i & imem_sel_i & ~if2icache_req_kill_i;
  assign hit       = lookup & (|hit_way_i);
  assign miss      = lookup & ~(|hit_way_i);
  assign abort     = if2icache_req_kill_i | ~imem_sel_i;
  assign last_beat = (beat_q == BEAT_W'(LINE_BEATS - 1));

  always_comb begin
    state_d          = state_q;
    icache2mem_req_o = 1'b0;
    cache_wr_o       = 1'b0;
    tag_wr_o         = 1'b0;
    start_fill       = 1'b0;
    fill_done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss) begin
          icache2mem_req_o = 1'b1;
          start_fill       = 1'b1;
          state_d          = FILL;
        end
      end
      FILL: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          icache2mem_req_o = 1'b1;
          if (mem2icache_ack_i) begin
            cache_wr_o = 1'b1;
            if (last_beat) begin
              tag_wr_o         = 1'b1;
              icache2mem_req_o = 1'b0;
              fill_done        = 1'b1;
              state_d          = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      set_q   <= '0;
      way_q   <= '0;
      beat_q  <= '0;
      for (int unsigned i = 0; i < NUM_SETS; i++) rr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_q == IDLE) & hit;
      if (start_fill) begin
        set_q  <= set_idx_i;
        way_q  <= rr_q[set_idx_i];
        beat_q <= '0;
      end
      // Counter stops on the final beat so fill_beat_o keeps the last written beat while idle.
      if (cache_wr_o && !last_beat) beat_q <= beat_q + BEAT_W'(1);
      if (fill_done) rr_q[set_q] <= rr_q[set_q] + WAY_W'(1);
    end
  end

  assign icache2if_ack_o = ack_q;
  assign fill_way_o      = way_q;
  assign fill_beat_o     = beat_q;
  assign busy_o          = (state_q == FILL);

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if ((state_q == IDLE) && hit && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (start_fill && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_ctrl_nway.sv
// Directed self-checking bench for icache_ctrl_nway (default 4 ways, 64 sets, 4 beats).
module tb_icache_ctrl_nway;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       if2icache_req_i;
  logic       if2icache_req_kill_i;
  logic       imem_sel_i;
  logic [5:0] set_idx_i;
  logic [3:0] hit_way_i;
  logic       icache2if_ack_o;
  logic       icache2mem_req_o;
  logic       mem2icache_ack_i;
  logic [1:0] fill_way_o;
  logic [1:0] fill_beat_o;
  logic       cache_wr_o;
  logic       tag_wr_o;
  logic       busy_o;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  icache_ctrl_nway #(.NUM_WAYS(4), .NUM_SETS(64), .LINE_BEATS(4)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .if2icache_req_i     (if2icache_req_i),
    .if2icache_req_kill_i(if2icache_req_kill_i),
    .imem_sel_i          (imem_sel_i),
    .set_idx_i           (set_idx_i),
    .hit_way_i           (hit_way_i),
    .icache2if_ack_o     (icache2if_ack_o),
    .icache2mem_req_o    (icache2mem_req_o),
    .mem2icache_ack_i    (mem2icache_ack_i),
    .fill_way_o          (fill_way_o),
    .fill_beat_o         (fill_beat_o),
    .cache_wr_o          (cache_wr_o),
    .tag_wr_o            (tag_wr_o),
    .busy_o              (busy_o)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt_o           (hit_cnt_o),
    .miss_cnt_o          (miss_cnt_o)
`endif
  );

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic idle_inputs();
    if2icache_req_i      = 1'b0;
    if2icache_req_kill_i = 1'b0;
    imem_sel_i           = 1'b1;
    set_idx_i            = '0;
    hit_way_i            = '0;
    mem2icache_ack_i     = 1'b0;
  endtask

  task automatic next_cyc();
    @(negedge clk_i);
    idle_inputs();
  endtask

  // Issue a miss on set s, then supply four beats two cycles apart, checking each beat.
  task automatic run_fill(input logic [5:0] s, input logic [1:0] exp_way, input string tag);
    next_cyc();
    if2icache_req_i = 1'b1;
    set_idx_i       = s;
    #1;
    checks++;
    if (icache2mem_req_o !== 1'b1) begin
      errors++; $display("FAIL %s miss_req got %b want 1", tag, icache2mem_req_o);
    end
    for (int b = 0; b < 4; b++) begin
      next_cyc();
      #1;
      checks++;
      if (busy_o !== 1'b1 || fill_way_o !== exp_way || icache2mem_req_o !== 1'b1 || cache_wr_o !== 1'b0) begin
        errors++;
        $display("FAIL %s gap%0d busy=%b way=%0d req=%b wr=%b want busy=1 way=%0d req=1 wr=0",
                 tag, b, busy_o, fill_way_o, icache2mem_req_o, cache_wr_o, exp_way);
      end
      next_cyc();
      mem2icache_ack_i = 1'b1;
      #1;
      checks++;
      if (cache_wr_o !== 1'b1 || fill_beat_o !== 2'(b) || tag_wr_o !== (b == 3) ||
          icache2mem_req_o !== (b != 3)) begin
        errors++;
        $display("FAIL %s beat%0d wr=%b beat=%0d tag=%b req=%b want wr=1 beat=%0d tag=%b req=%b",
                 tag, b, cache_wr_o, fill_beat_o, tag_wr_o, icache2mem_req_o, b, b == 3, b != 3);
      end
    end
    next_cyc();
    #1;
    checks++;
    if (busy_o !== 1'b0 || cache_wr_o !== 1'b0 || tag_wr_o !== 1'b0) begin
      errors++; $display("FAIL %s done busy=%b wr=%b tag=%b want 0 0 0", tag, busy_o, cache_wr_o, tag_wr_o);
    end
  endtask

  // Miss on set s and deliver beats 0..n-1 back to back, leaving the controller in FILL.
  task automatic partial_fill(input logic [5:0] s, input int n);
    next_cyc();
    if2icache_req_i = 1'b1;
    set_idx_i       = s;
    for (int b = 0; b < n; b++) begin
      next_cyc();
      mem2icache_ack_i = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle_inputs();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({icache2if_ack_o, icache2mem_req_o, cache_wr_o, tag_wr_o, busy_o, fill_way_o, fill_beat_o} !== 9'b0) begin
      errors++;
      $display("FAIL reset ack=%b req=%b wr=%b tag=%b busy=%b way=%0d beat=%0d want all 0",
               icache2if_ack_o, icache2mem_req_o, cache_wr_o, tag_wr_o, busy_o, fill_way_o, fill_beat_o);
    end
  endtask

  task automatic test_hit();
    next_cyc();
    if2icache_req_i = 1'b1;
    hit_way_i       = 4'b0010;
    #1;
    checks++;
    if (icache2if_ack_o !== 1'b0 || icache2mem_req_o !== 1'b0) begin
      errors++; $display("FAIL hit_same ack=%b req=%b want 0 0", icache2if_ack_o, icache2mem_req_o);
    end
    next_cyc();
    #1;
    checks++;
    if (icache2if_ack_o !== 1'b1 || icache2mem_req_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL hit_ack ack=%b req=%b busy=%b want 1 0 0", icache2if_ack_o, icache2mem_req_o, busy_o);
    end
    next_cyc();
    #1;
    checks++;
    if (icache2if_ack_o !== 1'b0) begin
      errors++; $display("FAIL hit_pulse ack=%b want 0", icache2if_ack_o);
    end
  endtask

  task automatic test_fill_basic();
    run_fill(6'd5, 2'd0, "fill5_w0");
  endtask

  task automatic test_rr_wrap();
    run_fill(6'd5, 2'd1, "fill5_w1");
    run_fill(6'd5, 2'd2, "fill5_w2");
    run_fill(6'd6, 2'd0, "fill6_w0");
    run_fill(6'd5, 2'd3, "fill5_w3");
    run_fill(6'd5, 2'd0, "fill5_wrap");
  endtask

  task automatic test_kill_mid();
    partial_fill(6'd7, 2);
    next_cyc();
    if2icache_req_kill_i = 1'b1;
    #1;
    checks++;
    if (icache2mem_req_o !== 1'b0 || tag_wr_o !== 1'b0 || cache_wr_o !== 1'b0) begin
      errors++; $display("FAIL kill_mid req=%b tag=%b wr=%b want 0 0 0", icache2mem_req_o, tag_wr_o, cache_wr_o);
    end
    next_cyc();
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL kill_mid_idle busy=%b want 0", busy_o);
    end
    run_fill(6'd7, 2'd0, "kill_mid_reuse");
  endtask

  task automatic test_kill_final();
    partial_fill(6'd8, 3);
    next_cyc();
    mem2icache_ack_i     = 1'b1;
    if2icache_req_kill_i = 1'b1;
    #1;
    checks++;
    if (cache_wr_o !== 1'b0 || tag_wr_o !== 1'b0 || icache2mem_req_o !== 1'b0) begin
      errors++; $display("FAIL kill_final wr=%b tag=%b req=%b want 0 0 0", cache_wr_o, tag_wr_o, icache2mem_req_o);
    end
    next_cyc();
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL kill_final_idle busy=%b want 0", busy_o);
    end
    run_fill(6'd8, 2'd0, "kill_final_reuse");
  endtask

  task automatic test_idle_corner();
    next_cyc();
    if2icache_req_i      = 1'b1;
    if2icache_req_kill_i = 1'b1;
    set_idx_i            = 6'd9;
    #1;
    checks++;
    if (icache2mem_req_o !== 1'b0) begin
      errors++; $display("FAIL miss_kill_req req=%b want 0", icache2mem_req_o);
    end
    next_cyc();
    mem2icache_ack_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || cache_wr_o !== 1'b0 || tag_wr_o !== 1'b0 || icache2if_ack_o !== 1'b0) begin
      errors++; $display("FAIL idle_ack busy=%b wr=%b tag=%b ack=%b want 0 0 0 0",
                         busy_o, cache_wr_o, tag_wr_o, icache2if_ack_o);
    end
    // Multi-hot hit vector still counts as a hit.
    next_cyc();
    if2icache_req_i = 1'b1;
    hit_way_i       = 4'b0110;
    #1;
    checks++;
    if (icache2mem_req_o !== 1'b0) begin
      errors++; $display("FAIL multihit_req req=%b want 0", icache2mem_req_o);
    end
    next_cyc();
    #1;
    checks++;
    if (icache2if_ack_o !== 1'b1) begin
      errors++; $display("FAIL multihit_ack ack=%b want 1", icache2if_ack_o);
    end
  endtask

  task automatic test_reset_midfill();
    partial_fill(6'd10, 1);
    next_cyc();
    rst_i = 1'b1;
    next_cyc();
    rst_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || tag_wr_o !== 1'b0 || icache2mem_req_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid busy=%b tag=%b req=%b want 0 0 0", busy_o, tag_wr_o, icache2mem_req_o);
    end
    run_fill(6'd5, 2'd0, "reset_ptr_clear");
  endtask

`ifdef ICACHE_PERF_CNT_EN
  task automatic test_perf_cnt();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      if2icache_req_i = 1'b1;
      hit_way_i       = 4'b0001;
    end
    next_cyc();
    if2icache_req_i      = 1'b1;
    if2icache_req_kill_i = 1'b1;
    run_fill(6'd1, 2'd0, "perf_m1");
    run_fill(6'd2, 2'd0, "perf_m2");
    #1;
    checks++;
    if (hit_cnt_o !== 32'd3 || miss_cnt_o !== 32'd2) begin
      errors++; $display("FAIL perf_cnt hit=%0d miss=%0d want 3 2", hit_cnt_o, miss_cnt_o);
    end
  endtask
`endif

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    test_reset();
    test_hit();
    test_fill_basic();
    test_rr_wrap();
    test_kill_mid();
    test_kill_final();
    test_idle_corner();
    test_reset_midfill();
`ifdef ICACHE_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
